// File: rtl/vx_cache_flush.sv
// Flush walker for one cache bank: visits every (line, way) tag entry, writes back
// valid dirty lines over a valid/ready handshake, invalidates valid lines, then pulses done.
module vx_cache_flush #(
  parameter int CACHE_SIZE = 16384,
  parameter int LINE_SIZE  = 64,
  parameter int NUM_BANKS  = 1,
  parameter int NUM_WAYS   = 1,
  parameter int TAG_WIDTH  = 20,
  localparam int NUM_LINES     = CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS),
  localparam int LINE_SEL_BITS = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1,
  localparam int WAY_SEL_BITS  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_req_valid,
  output logic                     flush_req_ready,
  output logic                     busy,
  output logic                     tag_rd_valid,
  output logic [LINE_SEL_BITS-1:0] tag_rd_line,
  output logic [WAY_SEL_BITS-1:0]  tag_rd_way,
  input  logic                     tag_rsp_valid_bit,
  input  logic                     tag_rsp_dirty,
  input  logic [TAG_WIDTH-1:0]     tag_rsp_tag,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [LINE_SEL_BITS-1:0] wb_line,
  output logic [WAY_SEL_BITS-1:0]  wb_way,
  output logic [TAG_WIDTH-1:0]     wb_tag,
  output logic                     inv_valid,
  output logic [LINE_SEL_BITS-1:0] inv_line,
  output logic [WAY_SEL_BITS-1:0]  inv_way,
  output logic                     done_valid
);

  localparam logic [LINE_SEL_BITS-1:0] LAST_LINE = LINE_SEL_BITS'(NUM_LINES - 1);
  localparam logic [WAY_SEL_BITS-1:0]  LAST_WAY  = WAY_SEL_BITS'(NUM_WAYS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CHECK,
    S_WB,
    S_INV,
    S_DONE
  } state_t;

  state_t                     state, state_n;
  logic [LINE_SEL_BITS-1:0]   line_ctr, line_n;
  logic [WAY_SEL_BITS-1:0]    way_ctr, way_n;
  logic [TAG_WIDTH-1:0]       tag_p1;
  logic                       advance;
  logic                       last_entry;

  // control state: counters and walker state
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      line_ctr <= '0;
      way_ctr  <= '0;
    end else begin
      state    <= state_n;
      line_ctr <= line_n;
      way_ctr  <= way_n;
    end
  end

  // tag response is only valid in the CHECK cycle; hold it for the writeback
  always_ff @(posedge clk) begin
    if (state == S_CHECK) begin
      tag_p1 <= tag_rsp_tag;
    end
  end

  assign last_entry = (line_ctr == LAST_LINE) && (way_ctr == LAST_WAY);
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_n         = state;
    line_n          = line_ctr;
    way_n           = way_ctr;
    advance         = 1'b0;
    flush_req_ready = 1'b0;
    tag_rd_valid    = 1'b0;
    tag_rd_line     = '0;
    tag_rd_way      = '0;
    wb_valid        = 1'b0;
    wb_line         = '0;
    wb_way          = '0;
    wb_tag          = '0;
    inv_valid       = 1'b0;
    inv_line        = '0;
    inv_way         = '0;
    done_valid      = 1'b0;

    case (state)
      S_IDLE: begin
        flush_req_ready = 1'b1;
        if (flush_req_valid) begin
          line_n  = '0;
          way_n   = '0;
          state_n = S_READ;
        end
      end
      S_READ: begin
        tag_rd_valid = 1'b1;
        tag_rd_line  = line_ctr;
        tag_rd_way   = way_ctr;
        state_n      = S_CHECK;
      end
      S_CHECK: begin
        if (!tag_rsp_valid_bit) begin
          advance = 1'b1;
        end else if (tag_rsp_dirty) begin
          state_n = S_WB;
        end else begin
          state_n = S_INV;
        end
      end
      S_WB: begin
        wb_valid = 1'b1;
        wb_line  = line_ctr;
        wb_way   = way_ctr;
        wb_tag   = tag_p1;
        if (wb_ready) begin
          state_n = S_INV;
        end
      end
      S_INV: begin
        inv_valid = 1'b1;
        inv_line  = line_ctr;
        inv_way   = way_ctr;
        advance   = 1'b1;
      end
      S_DONE: begin
        done_valid = 1'b1;
        state_n    = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // way is the inner index; compare against last indices rather than relying on wrap
    if (advance) begin
      if (last_entry) begin
        state_n = S_DONE;
      end else begin
        state_n = S_READ;
        if (way_ctr == LAST_WAY) begin
          way_n  = '0;
          line_n = line_ctr + 1'b1;
        end else begin
          way_n = way_ctr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_cache_flush.sv
// Bench for vx_cache_flush: 4 lines x 2 ways, tag store and memory side modelled here.
module tb_vx_cache_flush;

  localparam int NE  = 8;
  localparam int LSB = 2;
  localparam int WSB = 1;
  localparam int TW  = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           flush_req_valid;
  logic           flush_req_ready;
  logic           busy;
  logic           tag_rd_valid;
  logic [LSB-1:0] tag_rd_line;
  logic [WSB-1:0] tag_rd_way;
  logic           tag_rsp_valid_bit;
  logic           tag_rsp_dirty;
  logic [TW-1:0]  tag_rsp_tag;
  logic           wb_valid;
  logic           wb_ready;
  logic [LSB-1:0] wb_line;
  logic [WSB-1:0] wb_way;
  logic [TW-1:0]  wb_tag;
  logic           inv_valid;
  logic [LSB-1:0] inv_line;
  logic [WSB-1:0] inv_way;
  logic           done_valid;

  vx_cache_flush #(
    .CACHE_SIZE(64), .LINE_SIZE(4), .NUM_BANKS(2), .NUM_WAYS(2), .TAG_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .flush_req_valid(flush_req_valid), .flush_req_ready(flush_req_ready), .busy(busy),
    .tag_rd_valid(tag_rd_valid), .tag_rd_line(tag_rd_line), .tag_rd_way(tag_rd_way),
    .tag_rsp_valid_bit(tag_rsp_valid_bit), .tag_rsp_dirty(tag_rsp_dirty), .tag_rsp_tag(tag_rsp_tag),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_line(wb_line), .wb_way(wb_way), .wb_tag(wb_tag),
    .inv_valid(inv_valid), .inv_line(inv_line), .inv_way(inv_way), .done_valid(done_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // tag store contents seen by the walker
  logic          sv[NE];
  logic          sd[NE];
  logic [TW-1:0] st[NE];
  bit            pend;
  int            pidx;

  typedef struct {
    logic [7:0] vmask;
    logic [7:0] dmask;
    logic [7:0] tbase;
    int         stall;
    int         e_wb;
    int         e_inv;
    int         e_lat;
    int         e_wb0;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // one clock: respond to last cycle's read, then sample at the falling edge
  task automatic step();
    @(posedge clk);
    #1;
    if (pend) begin
      tag_rsp_valid_bit = sv[pidx];
      tag_rsp_dirty     = sd[pidx];
      tag_rsp_tag       = st[pidx];
    end else begin
      tag_rsp_valid_bit = 1'($urandom_range(0, 1));
      tag_rsp_dirty     = 1'($urandom_range(0, 1));
      tag_rsp_tag       = 8'($urandom);
    end
    pend = 0;
    @(negedge clk);
    if (tag_rd_valid) begin
      pend = 1;
      pidx = int'(tag_rd_line) * 2 + int'(tag_rd_way);
    end
    if (inv_valid) begin
      sv[int'(inv_line) * 2 + int'(inv_way)] = 1'b0;
      sd[int'(inv_line) * 2 + int'(inv_way)] = 1'b0;
    end
  endtask

  task automatic load_store(input logic [7:0] vm, input logic [7:0] dm, input logic [7:0] base);
    for (int i = 0; i < NE; i++) begin
      sv[i] = vm[i];
      sd[i] = dm[i];
      st[i] = base + 8'(i * 17);
    end
  endtask

  // Runs one flush from IDLE (caller at a falling edge) and checks it against the entry-cost model.
  task automatic run_flush(input int stall, input bit rnd, output int n_wb, output int n_inv,
                           output int lat, output int wb0);
    int exp_rd[$], exp_wb[$], exp_wbt[$], exp_inv[$];
    int got_rd[$], got_wb[$], got_wbt[$], got_inv[$];
    int cost, stalls, first, done_at, left, viol, ndone;
    bit in_wb;
    int p_idx, p_tag;
    cost = 1; stalls = 0; first = -1; done_at = -1; left = 0; viol = 0; ndone = 0;
    in_wb = 0; p_idx = 0; p_tag = 0;
    for (int i = 0; i < NE; i++) begin
      exp_rd.push_back(i);
      if (sv[i]) begin
        if (sd[i]) begin
          exp_wb.push_back(i);
          exp_wbt.push_back(int'(st[i]));
          cost += 4;
        end else begin
          cost += 3;
        end
        exp_inv.push_back(i);
      end else begin
        cost += 2;
      end
    end
    flush_req_valid = 1'b1;
    step();
    flush_req_valid = 1'b0;
    for (int c = 0; c < 300 && done_at < 0; c++) begin
      if ((int'(tag_rd_valid) + int'(wb_valid) + int'(inv_valid)) > 1) viol++;
      if (!busy || flush_req_ready) viol++;
      if (tag_rd_valid) begin
        got_rd.push_back(int'(tag_rd_line) * 2 + int'(tag_rd_way));
        if (first < 0) first = c;
      end
      if (wb_valid) begin
        if (in_wb) begin
          chk("wb_hold_addr", int'(wb_line) * 2 + int'(wb_way), p_idx);
          chk("wb_hold_tag", int'(wb_tag), p_tag);
        end else begin
          in_wb = 1;
          left  = stall;
        end
        p_idx = int'(wb_line) * 2 + int'(wb_way);
        p_tag = int'(wb_tag);
        if (rnd) wb_ready = 1'($urandom_range(0, 1));
        else if (left > 0) begin
          wb_ready = 1'b0;
          left--;
        end else wb_ready = 1'b1;
        if (!wb_ready) stalls++;
        else begin
          got_wb.push_back(p_idx);
          got_wbt.push_back(p_tag);
          in_wb = 0;
        end
      end else begin
        wb_ready = 1'($urandom_range(0, 1));
      end
      if (inv_valid) got_inv.push_back(int'(inv_line) * 2 + int'(inv_way));
      if (done_valid) begin
        done_at = c;
        ndone++;
      end
      step();
    end
    chk("walk_strobes_busy", viol, 0);
    if (done_at < 0) begin
      chk("done_timeout", 0, 1);
      lat = -1;
    end else begin
      lat = done_at - first + 1;
      chk("latency", lat, cost + stalls);
      chk("ready_after_done", int'(flush_req_ready), 1);
      chk("idle_after_done", int'(busy) + int'(done_valid), 0);
    end
    chk("done_pulses", ndone, 1);
    chk("n_reads", got_rd.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size(); i++)
      chk("read_order", (i < got_rd.size()) ? got_rd[i] : -1, exp_rd[i]);
    chk("n_wb", got_wb.size(), exp_wb.size());
    for (int i = 0; i < exp_wb.size(); i++) begin
      chk("wb_order", (i < got_wb.size()) ? got_wb[i] : -1, exp_wb[i]);
      chk("wb_tag", (i < got_wbt.size()) ? got_wbt[i] : -1, exp_wbt[i]);
    end
    chk("n_inv", got_inv.size(), exp_inv.size());
    for (int i = 0; i < exp_inv.size(); i++)
      chk("inv_order", (i < got_inv.size()) ? got_inv[i] : -1, exp_inv[i]);
    n_wb  = got_wb.size();
    n_inv = got_inv.size();
    wb0   = (got_wbt.size() > 0) ? got_wbt[0] : 0;
  endtask

  initial begin
    int nwb, ninv, lat, wb0, done_at, cnt;
    bit got2, fin;

    tbl[0] = '{8'h00, 8'h00, 8'h00, 0, 0, 0, 17, 0};
    tbl[1] = '{8'hFF, 8'h00, 8'h30, 0, 0, 8, 25, 0};
    tbl[2] = '{8'h20, 8'h20, 8'h50, 5, 1, 1, 24, 8'hA5};
    tbl[3] = '{8'h81, 8'h81, 8'h10, 0, 2, 2, 21, 8'h10};
    tbl[4] = '{8'hF0, 8'h50, 8'h00, 2, 2, 4, 27, 8'h44};

    reset = 1'b1; flush_req_valid = 1'b0; wb_ready = 1'b0;
    tag_rsp_valid_bit = 1'b0; tag_rsp_dirty = 1'b0; tag_rsp_tag = '0;
    pend = 0; pidx = 0;
    load_store(8'h00, 8'h00, 8'h00);
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_ready", int'(flush_req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_strobes", int'(tag_rd_valid) + int'(wb_valid) + int'(inv_valid) + int'(done_valid), 0);
    chk("rst_addr", int'(tag_rd_line) + int'(tag_rd_way) + int'(wb_line) + int'(wb_way)
        + int'(wb_tag) + int'(inv_line) + int'(inv_way), 0);

    for (int k = 0; k < 5; k++) begin
      load_store(tbl[k].vmask, tbl[k].dmask, tbl[k].tbase);
      run_flush(tbl[k].stall, 1'b0, nwb, ninv, lat, wb0);
      chk($sformatf("vec%0d_wb", k), nwb, tbl[k].e_wb);
      chk($sformatf("vec%0d_inv", k), ninv, tbl[k].e_inv);
      chk($sformatf("vec%0d_lat", k), lat, tbl[k].e_lat);
      chk($sformatf("vec%0d_wb0tag", k), wb0, tbl[k].e_wb0);
      step();
    end

    for (int r = 0; r < 6; r++) begin
      load_store(8'($urandom), 8'($urandom), 8'($urandom));
      run_flush(0, 1'b1, nwb, ninv, lat, wb0);
      step();
    end

    // reset while a writeback to (1,0) is stalled
    load_store(8'h04, 8'h04, 8'h00);
    wb_ready = 1'b0;
    flush_req_valid = 1'b1;
    step();
    flush_req_valid = 1'b0;
    for (int c = 0; c < 50 && !wb_valid; c++) begin
      wb_ready = 1'b0;
      step();
    end
    chk("rst_reached_wb", int'(wb_valid), 1);
    chk("rst_wb_line", int'(wb_line), 1);
    reset = 1'b1;
    step();
    chk("abort_wb_valid", int'(wb_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(flush_req_ready), 1);
    chk("abort_done", int'(done_valid), 0);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      cnt += int'(done_valid) + int'(busy);
    end
    chk("abort_quiet", cnt, 0);
    run_flush(0, 1'b0, nwb, ninv, lat, wb0);
    chk("restart_wb_tag", wb0, 34);
    step();

    // request held high: second flush starts right after IDLE is re-entered
    load_store(8'h00, 8'h00, 8'h00);
    wb_ready = 1'b1;
    flush_req_valid = 1'b1;
    done_at = -1; got2 = 0; cnt = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (busy && flush_req_ready) cnt++;
      if (done_valid && done_at < 0) done_at = c;
      if (done_at >= 0 && c == done_at + 1) chk("held_ready_idle", int'(flush_req_ready), 1);
      if (done_at >= 0 && c == done_at + 2) begin
        chk("held_restart_read", int'(tag_rd_valid), 1);
        chk("held_restart_addr", int'(tag_rd_line) * 2 + int'(tag_rd_way), 0);
        got2 = 1;
        break;
      end
    end
    chk("held_restart_seen", int'(got2), 1);
    chk("held_ready_while_busy", cnt, 0);
    flush_req_valid = 1'b0;
    fin = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (done_valid) begin
        fin = 1;
        break;
      end
    end
    chk("held_second_done", int'(fin), 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
